// File: rtl/player_button_debouncer.sv
// rtl/player_button_debouncer.sv - two-channel button debouncer with single-cycle press pulses
//
// Conditions the two raw player-select buttons for the start menu.
// Each channel has a 2-flop synchronizer followed by a debounce FSM with a
// cycle counter. A press is reported once per debounced press, and a release
// must also be debounced before the next press can be reported. Player 1 has
// fixed priority over player 2 when both presses are accepted on the same edge.
//
// Ports:
//   clk          system clock (65 MHz pixel clock domain)
//   rst          asynchronous, active-high reset
//   btn1_raw     raw, asynchronous, bouncing button for player 1
//   btn2_raw     raw, asynchronous, bouncing button for player 2
//   player1      one-cycle pulse on a debounced press of button 1
//   player2      one-cycle pulse on a debounced press of button 2
//   btn1_stable  debounced level of button 1
//   btn2_stable  debounced level of button 2

module player_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic player1,
    output logic player2,
    output logic btn1_stable,
    output logic btn2_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [1:0] raw_v;
    logic [1:0] req;
    logic [1:0] stable_v;

    assign raw_v = {btn2_raw, btn1_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic             stable;
        state_t           state;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                stable <= 1'b0;
                state  <= IDLE;
                cnt    <= '0;
            end else begin
                sync1 <= raw_v[ch];
                sync2 <= sync1;
                case (state)
                    IDLE: begin
                        if (sync2) begin
                            state <= WAIT_HIGH;
                            cnt   <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync2) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state  <= PRESSED;
                            stable <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync2) begin
                            state <= WAIT_LOW;
                            cnt   <= '0;
                        end
                    end
                    WAIT_LOW: begin
                        // A high sample here is release bounce: fall back to
                        // PRESSED without reporting a new press.
                        if (sync2) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state  <= IDLE;
                            stable <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        // Request is asserted on the edge that moves WAIT_HIGH -> PRESSED,
        // so the registered pulse appears in the following cycle.
        assign req[ch]      = (state == WAIT_HIGH) && sync2 && (cnt == CNT_MAX);
        assign stable_v[ch] = stable;
    end

    // Fixed priority: a simultaneous player-2 request is dropped, not deferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player1 <= 1'b0;
            player2 <= 1'b0;
        end else begin
            player1 <= req[0];
            player2 <= req[1] & ~req[0];
        end
    end

    assign btn1_stable = stable_v[0];
    assign btn2_stable = stable_v[1];

endmodule
